// File: rtl/inst_sram_resp.sv
// ----------------------------------------------------------------------------
// inst_sram_resp
//
// Single-port instruction SRAM responder for the fetch stage. Requests on the
// inst_sram_* port get a response exactly one cycle later, with no wait
// states. The read data register holds its value while no request is issued,
// so a stalled fetch stage keeps seeing a valid instruction.
//
// Only a fixed physical window starting at BASE is backed by memory. A request
// outside that window returns a NOP (32'h0), raises oob_err for one response
// cycle and never touches the memory. A side load port lets a testbench or
// boot loader preload program words whenever the core port is idle.
// Saturating counters record accepted reads, writes and out-of-window hits
// for debug.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   inst_sram_en      request strobe
//   inst_sram_wen     byte write enables (0 = read)
//   inst_sram_addr    byte address
//   inst_sram_wdata   write data
//   inst_sram_rdata   read data, valid the cycle after the request
//   oob_err           last accepted request was outside the window
//   ld_valid/ld_ready preload handshake (ready only while core port idle)
//   ld_addr/ld_data   preload word index and full-word data
//   rd_cnt/wr_cnt     accepted read / write requests, saturating
//   oob_cnt           out-of-window requests, saturating
// ----------------------------------------------------------------------------
module inst_sram_resp #(
    parameter int          ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'hbfc00000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_sram_en,
    input  logic [3:0]        inst_sram_wen,
    input  logic [31:0]       inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic [31:0]       inst_sram_rdata,
    output logic              oob_err,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       oob_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_rdata;
    logic              r_oobErr;
    logic [31:0]       r_rdCnt;
    logic [31:0]       r_wrCnt;
    logic [31:0]       r_oobCnt;

    logic              w_hit;
    logic              w_isWrite;
    logic [ADDR_W-1:0] w_index;
    logic              w_ldAccept;

    // Window decode compares only the tag bits above the word index; the two
    // byte-offset bits are ignored because alignment is the fetch stage's job.
    assign w_hit     = (inst_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
    assign w_index   = inst_sram_addr[ADDR_W+1:2];
    assign w_isWrite = (inst_sram_wen != 4'b0000);

    // The core port always wins; preload is also blocked throughout reset.
    assign ld_ready   = !inst_sram_en && !reset;
    assign w_ldAccept = ld_valid && ld_ready;

    // Memory array has no reset so preloaded programs survive a core reset.
    // Core writes are byte-masked; preload writes are always full words.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (inst_sram_en && w_hit && w_isWrite) begin
                for (int i = 0; i < 4; i++) begin
                    if (inst_sram_wen[i]) begin
                        r_mem[w_index][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
                    end
                end
            end else if (w_ldAccept) begin
                r_mem[ld_addr] <= ld_data;
            end
        end
    end

    // Response path: read-first, so a write returns the word as it was before
    // the write. Without a request the data register simply holds, while the
    // error flag clears so it only ever describes the most recent response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata  <= 32'h0;
            r_oobErr <= 1'b0;
        end else if (inst_sram_en) begin
            r_rdata  <= w_hit ? r_mem[w_index] : 32'h0;
            r_oobErr <= !w_hit;
        end else begin
            r_oobErr <= 1'b0;
        end
    end

    // Debug counters stick at all-ones instead of wrapping. Out-of-window
    // requests still count as reads or writes by their enable type.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdCnt  <= 32'h0;
            r_wrCnt  <= 32'h0;
            r_oobCnt <= 32'h0;
        end else if (inst_sram_en) begin
            if (!w_isWrite && (r_rdCnt != 32'hffffffff)) begin
                r_rdCnt <= r_rdCnt + 32'd1;
            end
            if (w_isWrite && (r_wrCnt != 32'hffffffff)) begin
                r_wrCnt <= r_wrCnt + 32'd1;
            end
            if (!w_hit && (r_oobCnt != 32'hffffffff)) begin
                r_oobCnt <= r_oobCnt + 32'd1;
            end
        end
    end

    assign inst_sram_rdata = r_rdata;
    assign oob_err         = r_oobErr;
    assign rd_cnt          = r_rdCnt;
    assign wr_cnt          = r_wrCnt;
    assign oob_cnt         = r_oobCnt;

endmodule

// File: tb/tb_inst_sram_resp.sv
// ----------------------------------------------------------------------------
// tb_inst_sram_resp
//
// Self-checking bench for inst_sram_resp. Each cycle of stimulus is also fed
// to a small behavioural model; the model's predicted response is pushed to a
// scoreboard queue and popped after the clock edge, when the DUT has produced
// its response.
// ----------------------------------------------------------------------------
module tb_inst_sram_resp;

    localparam int          ADDR_W = 12;
    localparam logic [31:0] BASE   = 32'hbfc00000;

    logic              clk;
    logic              reset;
    logic              inst_sram_en;
    logic [3:0]        inst_sram_wen;
    logic [31:0]       inst_sram_addr;
    logic [31:0]       inst_sram_wdata;
    logic [31:0]       inst_sram_rdata;
    logic              oob_err;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic [31:0]       rd_cnt;
    logic [31:0]       wr_cnt;
    logic [31:0]       oob_cnt;

    typedef struct packed {
        logic [31:0] rdata;
        logic        oob;
        logic [31:0] rdCnt;
        logic [31:0] wrCnt;
        logic [31:0] oobCnt;
    } expect_t;

    expect_t     scoreboard[$];
    logic [31:0] modelMem [1 << ADDR_W];
    logic [31:0] modelRdata;
    logic        modelOob;
    logic [31:0] modelRdCnt;
    logic [31:0] modelWrCnt;
    logic [31:0] modelOobCnt;

    int vectorCount;
    int missCount;

    inst_sram_resp #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .oob_err         (oob_err),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_addr         (ld_addr),
        .ld_data         (ld_data),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt),
        .oob_cnt         (oob_cnt)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hffffffff) ? v : v + 32'd1;
    endfunction

    // Drive one cycle of stimulus, update the model, push the prediction,
    // then take the clock edge and compare the DUT against the popped entry.
    task automatic applyStimulus(input logic rst, input logic en,
                                 input logic [3:0] wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic ldv,
                                 input logic [ADDR_W-1:0] lda,
                                 input logic [31:0] ldd);
        logic              hit;
        logic [ADDR_W-1:0] idx;
        expect_t           exp;
        expect_t           got;
        reset           = rst;
        inst_sram_en    = en;
        inst_sram_wen   = wen;
        inst_sram_addr  = addr;
        inst_sram_wdata = wdata;
        ld_valid        = ldv;
        ld_addr         = lda;
        ld_data         = ldd;
        #1;
        checkOutput("ld_ready", {31'h0, ld_ready}, {31'h0, (!en && !rst)});

        hit = (addr[31:14] == BASE[31:14]);
        idx = addr[13:2];
        if (rst) begin
            modelRdata  = 32'h0;
            modelOob    = 1'b0;
            modelRdCnt  = 32'h0;
            modelWrCnt  = 32'h0;
            modelOobCnt = 32'h0;
        end else if (en) begin
            modelRdata = hit ? modelMem[idx] : 32'h0;
            modelOob   = !hit;
            if (wen == 4'b0000) modelRdCnt = satInc(modelRdCnt);
            else                modelWrCnt = satInc(modelWrCnt);
            if (!hit) modelOobCnt = satInc(modelOobCnt);
            if (hit && wen != 4'b0000) begin
                for (int b = 0; b < 4; b++) begin
                    if (wen[b]) modelMem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else begin
            modelOob = 1'b0;
            if (ldv) modelMem[lda] = ldd;
        end
        exp.rdata  = modelRdata;
        exp.oob    = modelOob;
        exp.rdCnt  = modelRdCnt;
        exp.wrCnt  = modelWrCnt;
        exp.oobCnt = modelOobCnt;
        scoreboard.push_back(exp);

        @(posedge clk);
        #1;
        got = scoreboard.pop_front();
        checkOutput("rdata",   inst_sram_rdata,  got.rdata);
        checkOutput("oob_err", {31'h0, oob_err}, {31'h0, got.oob});
        checkOutput("rd_cnt",  rd_cnt,           got.rdCnt);
        checkOutput("wr_cnt",  wr_cnt,           got.wrCnt);
        checkOutput("oob_cnt", oob_cnt,          got.oobCnt);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, '0, 32'h0);
        end
    endtask

    task automatic readAt(input logic [31:0] addr);
        applyStimulus(1'b0, 1'b1, 4'h0, addr, 32'h0, 1'b0, '0, 32'h0);
    endtask

    task automatic writeAt(input logic [31:0] addr, input logic [3:0] wen,
                           input logic [31:0] wdata);
        applyStimulus(1'b0, 1'b1, wen, addr, wdata, 1'b0, '0, 32'h0);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] idx, input logic [31:0] data);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, idx, data);
    endtask

    initial begin
        logic [31:0] pattern [4];
        vectorCount = 0;
        missCount   = 0;
        modelRdata  = 32'h0;
        modelOob    = 1'b0;
        modelRdCnt  = 32'h0;
        modelWrCnt  = 32'h0;
        modelOobCnt = 32'h0;
        pattern[0] = 32'h11111111;
        pattern[1] = 32'h22222222;
        pattern[2] = 32'h33333333;
        pattern[3] = 32'h44444444;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, '0, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, '0, 32'h0);

        // Preload words 0..3, then back-to-back reads.
        for (int i = 0; i < 4; i++) preload(ADDR_W'(i), pattern[i]);
        readAt(32'hbfc00000);
        readAt(32'hbfc00004);
        readAt(32'hbfc00008);
        checkOutput("rd_cnt_after_3", rd_cnt, 32'd3);

        // Read data holds while the core port is idle.
        readAt(32'hbfc00004);
        idle(5);
        checkOutput("rdata_hold", inst_sram_rdata, 32'h22222222);

        // Byte-masked write is read-first; following read sees the merge.
        writeAt(32'hbfc00008, 4'b0101, 32'haabbccdd);
        checkOutput("write_read_first", inst_sram_rdata, 32'h33333333);
        readAt(32'hbfc00008);
        checkOutput("merged_word", inst_sram_rdata, 32'h33bb33dd);

        // Out-of-window read returns NOP and flags the error for one response.
        readAt(32'h80000000);
        checkOutput("oob_flag", {31'h0, oob_err}, 32'd1);
        idle(1);
        checkOutput("oob_cleared", {31'h0, oob_err}, 32'd0);

        // Out-of-window write whose low bits alias word 2 must not write.
        writeAt(32'hbfc10008, 4'b1111, 32'hdeadbeef);
        readAt(32'hbfc00008);

        // Preload blocked while the core is active, accepted once idle.
        applyStimulus(1'b0, 1'b1, 4'h0, 32'hbfc00000, 32'h0, 1'b1, 12'd5, 32'h5a5a1234);
        preload(12'd5, 32'h5a5a1234);
        readAt(32'hbfc00014);
        checkOutput("preload_word5", inst_sram_rdata, 32'h5a5a1234);

        // Mixed back-to-back traffic on words 8..15 with random lanes.
        for (int i = 8; i < 16; i++) preload(ADDR_W'(i), $urandom);
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = BASE | (32'($urandom_range(8, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) readAt(a);
            else writeAt(a, 4'($urandom_range(1, 15)), $urandom);
        end

        // Reset mid-stream: a request and preload present during reset are
        // ignored, and memory contents survive.
        readAt(32'hbfc00004);
        applyStimulus(1'b1, 1'b1, 4'hf, 32'hbfc00000, 32'hcafef00d, 1'b1, 12'd0, 32'h0badf00d);
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 12'd1, 32'h0badf00d);
        checkOutput("reset_rdata", inst_sram_rdata, 32'h0);
        checkOutput("reset_rd_cnt", rd_cnt, 32'h0);
        readAt(32'hbfc00000);
        checkOutput("post_reset_word0", inst_sram_rdata, 32'h11111111);
        readAt(32'hbfc00004);
        checkOutput("post_reset_word1", inst_sram_rdata, 32'h22222222);

        if (scoreboard.size() != 0) begin
            checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
